// File: rtl/board_referee.sv
// Tic-tac-toe board owner: places marks, enforces the rolling per-player mark
// limit by erasing each player's oldest mark, and registers three-in-a-row results.
module board_referee #(
  parameter int MAX_MARKS = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] location_i,
  input  logic [1:0] mark_i,
  output logic [1:0] a0_o,
  output logic [1:0] a1_o,
  output logic [1:0] a2_o,
  output logic [1:0] a3_o,
  output logic [1:0] a4_o,
  output logic [1:0] a5_o,
  output logic [1:0] a6_o,
  output logic [1:0] a7_o,
  output logic [1:0] a8_o,
  output logic [1:0] gameend_o,
  output logic [7:0] winLine_o,
  output logic [2:0] cntX_o,
  output logic [2:0] cntO_o
);

  localparam logic [2:0] MaxCnt = 3'(MAX_MARKS);

  logic [1:0] board_q [9];
  logic [1:0] board_d [9];
  logic [3:0] histX_q [4];
  logic [3:0] histX_d [4];
  logic [3:0] histO_q [4];
  logic [3:0] histO_d [4];
  logic [2:0] cntX_q, cntX_d;
  logic [2:0] cntO_q, cntO_d;
  logic [5:0] prevPair_q;
  logic [1:0] gameend_q, gameend_d;
  logic [7:0] winLine_q, winLine_d;

  logic       markLegal;
  logic       cellEmpty;
  logic       moveEvent;
  logic [8:0] xMask, oMask;
  logic [7:0] xLines, oLines;

  function automatic logic [7:0] lineHits(input logic [8:0] m);
    return {m[2] & m[4] & m[6], m[0] & m[4] & m[8],
            m[2] & m[5] & m[8], m[1] & m[4] & m[7],
            m[0] & m[3] & m[6], m[6] & m[7] & m[8],
            m[3] & m[4] & m[5], m[0] & m[1] & m[2]};
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      xMask[i] = (board_q[i] == 2'b10);
      oMask[i] = (board_q[i] == 2'b01);
    end
    xLines = lineHits(xMask);
    oLines = lineHits(oMask);
  end

  // A held pair fires once: it must differ from the pair seen on the previous edge.
  always_comb begin
    markLegal = (mark_i == 2'b10) || (mark_i == 2'b01);
    cellEmpty = (location_i <= 4'd8) ? (board_q[location_i] == 2'b00) : 1'b0;
    moveEvent = markLegal && (location_i <= 4'd8) &&
                ({mark_i, location_i} != prevPair_q) &&
                cellEmpty && (gameend_q == 2'b00);
  end

  always_comb begin
    board_d   = board_q;
    histX_d   = histX_q;
    histO_d   = histO_q;
    cntX_d    = cntX_q;
    cntO_d    = cntO_q;
    gameend_d = gameend_q;
    winLine_d = winLine_q;

    if (moveEvent) begin
      if (mark_i == 2'b10) begin
        if (cntX_q == MaxCnt) begin
          board_d[histX_q[0]] = 2'b00;
          for (int i = 0; i < 3; i++) histX_d[i] = histX_q[i+1];
          histX_d[MAX_MARKS-1] = location_i;
        end else begin
          histX_d[cntX_q[1:0]] = location_i;
          cntX_d = cntX_q + 3'd1;
        end
      end else begin
        if (cntO_q == MaxCnt) begin
          board_d[histO_q[0]] = 2'b00;
          for (int i = 0; i < 3; i++) histO_d[i] = histO_q[i+1];
          histO_d[MAX_MARKS-1] = location_i;
        end else begin
          histO_d[cntO_q[1:0]] = location_i;
          cntO_d = cntO_q + 3'd1;
        end
      end
      board_d[location_i] = mark_i;
    end

    // Lines are judged on the registered (post-elimination) board, so results lag by one edge.
    if (gameend_q == 2'b00) begin
      if (|xLines) begin
        gameend_d = 2'b10;
        winLine_d = xLines;
      end else if (|oLines) begin
        gameend_d = 2'b01;
        winLine_d = oLines;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
      for (int i = 0; i < 4; i++) begin
        histX_q[i] <= 4'd0;
        histO_q[i] <= 4'd0;
      end
      cntX_q     <= 3'd0;
      cntO_q     <= 3'd0;
      prevPair_q <= {2'b00, 4'd9};
      gameend_q  <= 2'b00;
      winLine_q  <= 8'd0;
    end else begin
      board_q    <= board_d;
      histX_q    <= histX_d;
      histO_q    <= histO_d;
      cntX_q     <= cntX_d;
      cntO_q     <= cntO_d;
      prevPair_q <= {mark_i, location_i};
      gameend_q  <= gameend_d;
      winLine_q  <= winLine_d;
    end
  end

  assign a0_o      = board_q[0];
  assign a1_o      = board_q[1];
  assign a2_o      = board_q[2];
  assign a3_o      = board_q[3];
  assign a4_o      = board_q[4];
  assign a5_o      = board_q[5];
  assign a6_o      = board_q[6];
  assign a7_o      = board_q[7];
  assign a8_o      = board_q[8];
  assign gameend_o = gameend_q;
  assign winLine_o = winLine_q;
  assign cntX_o    = cntX_q;
  assign cntO_o    = cntO_q;

endmodule

// File: tb/tb_board_referee.sv
// Scoreboard bench for board_referee: a move-level reference model queues the
// expected board after each move, and the settled DUT outputs are checked against it.
module tb_board_referee;

  localparam int MAXM = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] location;
  logic [1:0] mark;
  logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [1:0] gameend;
  logic [7:0] winLine;
  logic [2:0] cntX, cntO;

  board_referee #(.MAX_MARKS(MAXM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .location_i(location), .mark_i(mark),
    .a0_o(a0), .a1_o(a1), .a2_o(a2), .a3_o(a3), .a4_o(a4),
    .a5_o(a5), .a6_o(a6), .a7_o(a7), .a8_o(a8),
    .gameend_o(gameend), .winLine_o(winLine), .cntX_o(cntX), .cntO_o(cntO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] board;
    logic [1:0]  ge;
    logic [7:0]  win;
    logic [2:0]  cx;
    logic [2:0]  co;
  } snap_t;

  snap_t expQ[$];
  string tagQ[$];
  int    passCount  = 0;
  int    checkCount = 0;

  logic [1:0] mBoard [9];
  int         qX[$];
  int         qO[$];
  logic [1:0] mEnd;
  logic [7:0] mWin;
  logic [5:0] mPrev;
  int lineCells [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] dutBoard();
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [7:0] modelLines(input logic [1:0] c);
    logic [7:0] r;
    r = '0;
    for (int l = 0; l < 8; l++)
      r[l] = (mBoard[lineCells[l][0]] == c) && (mBoard[lineCells[l][1]] == c) &&
             (mBoard[lineCells[l][2]] == c);
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 9; i++) mBoard[i] = 2'b00;
    qX.delete();
    qO.delete();
    mEnd  = 2'b00;
    mWin  = 8'h00;
    mPrev = {2'b00, 4'd9};
  endtask

  // Move-level model: a held pair acts once, then the win is judged on the resulting board.
  task automatic modelMove(input logic [1:0] m, input logic [3:0] l);
    logic [7:0] xl, ol;
    if ((m == 2'b10 || m == 2'b01) && l <= 4'd8 && {m, l} != mPrev &&
        mBoard[l] == 2'b00 && mEnd == 2'b00) begin
      if (m == 2'b10) begin
        if (qX.size() == MAXM) mBoard[qX.pop_front()] = 2'b00;
        qX.push_back(int'(l));
      end else begin
        if (qO.size() == MAXM) mBoard[qO.pop_front()] = 2'b00;
        qO.push_back(int'(l));
      end
      mBoard[l] = m;
    end
    mPrev = {m, l};
    if (mEnd == 2'b00) begin
      xl = modelLines(2'b10);
      ol = modelLines(2'b01);
      if (|xl) begin mEnd = 2'b10; mWin = xl; end
      else if (|ol) begin mEnd = 2'b01; mWin = ol; end
    end
  endtask

  task automatic pushSnapshot(input string tag);
    snap_t s;
    for (int i = 0; i < 9; i++) s.board[2*i +: 2] = mBoard[i];
    s.ge  = mEnd;
    s.win = mWin;
    s.cx  = 3'(qX.size());
    s.co  = 3'(qO.size());
    expQ.push_back(s);
    tagQ.push_back(tag);
  endtask

  task automatic popAndCompare();
    snap_t s;
    string t;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard underflow", 32'd1, 32'd0);
      return;
    end
    s = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput({t, " board"},   32'(dutBoard()), 32'(s.board));
    checkOutput({t, " gameend"}, 32'(gameend),    32'(s.ge));
    checkOutput({t, " winLine"}, 32'(winLine),    32'(s.win));
    checkOutput({t, " cntX"},    32'(cntX),       32'(s.cx));
    checkOutput({t, " cntO"},    32'(cntO),       32'(s.co));
  endtask

  task automatic driveMove(input logic [1:0] m, input logic [3:0] l, input string tag);
    mark     = m;
    location = l;
    modelMove(m, l);
    pushSnapshot(tag);
  endtask

  task automatic settle(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    popAndCompare();
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] l, input int hold,
                               input string tag);
    driveMove(m, l, tag);
    settle(hold);
  endtask

  task automatic doReset(input string tag);
    mark     = 2'b00;
    location = 4'd9;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    modelReset();
    pushSnapshot(tag);
    popAndCompare();
    rst_n = 1'b1;
  endtask

  initial begin
    mark     = 2'b00;
    location = 4'd9;
    rst_n    = 1'b0;
    @(negedge clk);

    doReset("T1 reset");

    applyStimulus(2'b10, 4'd0, 3, "T2 X0");
    applyStimulus(2'b01, 4'd3, 3, "T2 O3");
    applyStimulus(2'b10, 4'd1, 3, "T2 X1");
    applyStimulus(2'b01, 4'd4, 3, "T2 O4");
    driveMove(2'b10, 4'd2, "T2 X2");
    @(posedge clk); #1;
    checkOutput("T2 a0 at event", 32'(a0), 32'h2);
    checkOutput("T2 a2 at event", 32'(a2), 32'h2);
    checkOutput("T2 gameend at event", 32'(gameend), 32'h0);
    @(posedge clk); #1;
    checkOutput("T2 gameend next", 32'(gameend), 32'h2);
    checkOutput("T2 winLine next", 32'(winLine), 32'h01);
    settle(1);

    applyStimulus(2'b01, 4'd5, 3, "T6 frozen O5");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("T6 async board", 32'(dutBoard()), 32'h0);
    checkOutput("T6 async gameend", 32'(gameend), 32'h0);
    checkOutput("T6 async winLine", 32'(winLine), 32'h0);
    @(negedge clk);
    doReset("T6 reset");

    applyStimulus(2'b10, 4'd0, 3, "T3 X0");
    applyStimulus(2'b01, 4'd3, 3, "T3 O3");
    applyStimulus(2'b10, 4'd1, 3, "T3 X1");
    applyStimulus(2'b01, 4'd7, 3, "T3 O7");
    applyStimulus(2'b10, 4'd5, 3, "T3 X5");
    applyStimulus(2'b01, 4'd6, 3, "T3 O6");
    driveMove(2'b10, 4'd8, "T3 X8");
    @(posedge clk); #1;
    checkOutput("T3 a0 erased", 32'(a0), 32'h0);
    checkOutput("T3 a8 placed", 32'(a8), 32'h2);
    checkOutput("T3 cntX", 32'(cntX), 32'd3);
    settle(2);

    doReset("T4 reset");
    applyStimulus(2'b10, 4'd4, 10, "T4 hold X4");
    applyStimulus(2'b00, 4'd4, 2, "T4 gap");
    applyStimulus(2'b10, 4'd4, 3, "T4 repeat X4");

    applyStimulus(2'b01, 4'd9, 2, "T5 loc9");
    applyStimulus(2'b11, 4'd2, 2, "T5 mark11");
    applyStimulus(2'b01, 4'd4, 2, "T5 occupied");

    doReset("R reset");
    for (int n = 0; n < 40; n++) begin
      logic [1:0] rm;
      logic [3:0] rl;
      rm = 2'($urandom_range(0, 3));
      rl = 4'($urandom_range(0, 10));
      applyStimulus(rm, rl, 2, $sformatf("R%0d", n));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
